crc16_frame_feeder: RTL and testbench

//  Upstream feeder for the CRC_16_parallel_2 byte engine. Buffers an incoming byte

---
 rtl/crc16_frame_feeder.sv | 142 ++++++++++++++
 tb/tb_crc16_frame_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_feeder.sv
// Store-and-forward feeder for a byte-wide CRC-16 engine. It replays a whole
// stored frame to the engine without gaps, then appends the engine's CRC to the output.
// Latency: the first payload byte leaves 2 cycles after in_last is accepted (from IDLE).
//          An N-byte frame takes N+2 output cycles, and frames are separated by at least one idle cycle.
// Backpressure: in_ready = !full on the input side. The output has no backpressure.
//               An oversize frame is flushed and then sunk up to its in_last.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_data/in_valid/in_last     input byte stream; in_ready accepts it
//   eng_data/eng_valid, eng_crc  CRC engine interface (the engine clears whenever eng_valid=0)
//   out_data/out_valid/out_last  payload, then CRC[15:8], then CRC[7:0] (out_last)
//   busy, ovf_err                frame in flight; one-cycle oversize-drop pulse
module crc16_frame_feeder #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  eng_data,
  output logic        eng_valid,
  input  logic [15:0] eng_crc,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy,
  output logic        ovf_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, CAP = 2'd2, CRCL = 2'd3} state_t;

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [8:0]    mem [DEPTH];      // {last flag, byte}
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   frames_pend;      // complete frames stored but not yet started
  logic [7:0]    crc_hold;         // CRC low byte, kept for the final output cycle
  logic          drop;             // sinking the remainder of an oversize frame
  state_t        state;

  logic [8:0]    head;
  logic          full, accept, push, pop, start, ovf, inc, dec;

  assign head   = mem[rd_ptr[AW-1:0]];
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = drop || !full;
  assign accept = in_valid && in_ready;
  assign push   = accept && !drop;
  assign pop    = (state == FEED);
  assign start  = (state == IDLE) && (frames_pend != '0);
  // A full FIFO with no complete frame in it can never drain, so it holds an oversize frame.
  // The check is suppressed during FEED: a full-length resident frame is still full
  // on its first FEED cycle, after its pending count has already been consumed.
  assign ovf    = full && (frames_pend == '0) && (state != FEED);
  assign inc    = push && in_last;
  assign dec    = start;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else if (ovf) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (accept && drop && in_last) drop <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_pend <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   frames_pend <= frames_pend + PTR_ONE;
        2'b01:   frames_pend <= frames_pend - PTR_ONE;
        default: frames_pend <= frames_pend;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc_hold <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= FEED;
        FEED: if (head[8]) state <= CAP;
        CAP: begin
          crc_hold <= eng_crc[7:0];
          state    <= CRCL;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state. In CAP the engine's CRC is passed straight
  // through, because it only becomes valid in that cycle.
  always_comb begin
    eng_data  = 8'h00;
    eng_valid = 1'b0;
    out_data  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      FEED: begin
        eng_data  = head[7:0];
        eng_valid = 1'b1;
        out_data  = head[7:0];
        out_valid = 1'b1;
      end
      CAP: begin
        out_data  = eng_crc[15:8];
        out_valid = 1'b1;
      end
      CRCL: begin
        out_data  = crc_hold;
        out_valid = 1'b1;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state != IDLE);
  assign ovf_err = ovf;

endmodule

// File: tb/tb_crc16_frame_feeder.sv
// Directed bench for crc16_frame_feeder. It includes a behavioural CRC-16 engine
// (poly 0x1021, MSB first, seed 0, cleared whenever data_valid is low).
module tb_crc16_frame_feeder;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [7:0]  eng_data;
  logic        eng_valid;
  logic [15:0] eng_crc = 16'h0000;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy, ovf_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ev_run = 0;
  int ovf_cnt = 0;
  int eng_bad = 0;
  int lacc = 0;
  logic [8:0] oq[$];
  int         ocyc[$];
  int         runs[$];
  logic [7:0] fb[$];

  always #5 clk = ~clk;

  crc16_frame_feeder #(.DEPTH(DEPTH), .AW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .eng_data(eng_data), .eng_valid(eng_valid), .eng_crc(eng_crc),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .ovf_err(ovf_err)
  );

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int b = 0; b < 8; b++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always @(posedge clk) eng_crc <= eng_valid ? crc_step(eng_crc, eng_data) : 16'h0000;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      oq.push_back({out_last, out_data});
      ocyc.push_back(cyc);
    end
    if (eng_valid) ev_run <= ev_run + 1;
    else begin
      ev_run <= 0;
      if (ev_run != 0) runs.push_back(ev_run);
    end
    if (!eng_valid && eng_data != 8'h00) eng_bad <= eng_bad + 1;
    if (ovf_err) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted. Returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int k = 0;
    logic r = 1'b0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!r && k < 200) begin
      @(negedge clk);
      r = in_ready;
      lacc = cyc;
      tick();
      k++;
    end
    check("in_ready_wait", r, 1);
  endtask

  task automatic send_frame();
    for (int i = 0; i < fb.size(); i++) send_byte(fb[i], (i == fb.size() - 1));
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_out(input int n, input string tag);
    int k = 0;
    while (oq.size() < n && k < 400) begin
      tick();
      k++;
    end
    check({tag, "_arrived"}, (oq.size() >= n), 1);
    repeat (4) tick();
    check({tag, "_count"}, oq.size(), n);
  endtask

  task automatic check_frame(input int base, input string tag);
    logic [15:0] c;
    c = 16'h0000;
    foreach (fb[i]) c = crc_step(c, fb[i]);
    for (int i = 0; i < fb.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), oq[base+i], {1'b0, fb[i]});
    check({tag, "_crc_hi"}, oq[base+fb.size()], {1'b0, c[15:8]});
    check({tag, "_crc_lo"}, oq[base+fb.size()+1], {1'b1, c[7:0]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ob, rb, ov0, k, os;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_eng_valid", eng_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 1: single zero byte -> 00, 00, 00 (with out_last set on the third byte)
    ob = oq.size(); rb = runs.size();
    fb = '{8'h00};
    send_frame();
    wait_out(ob + 3, "t1");
    check("t1_b0", oq[ob], 9'h000);
    check("t1_b1", oq[ob+1], 9'h000);
    check("t1_b2", oq[ob+2], 9'h100);
    check("t1_latency", ocyc[ob] - lacc, 2);
    check("t1_runs", runs.size() - rb, 1);
    check("t1_run_len", runs[rb], 1);
    check("t1_busy_end", busy, 0);

    // 2: "123456789" -> CRC-16/XMODEM 0x31C3
    ob = oq.size(); rb = runs.size();
    fb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame();
    wait_out(ob + 11, "t2");
    check_frame(ob, "t2");
    check("t2_crc_const", {oq[ob+9][7:0], oq[ob+10][7:0]}, 16'h31C3);
    check("t2_runs", runs.size() - rb, 1);
    check("t2_run_len", runs[rb], 9);

    // 3: two 4-byte frames back to back -> 6 outputs, one idle cycle, 6 outputs
    ob = oq.size(); rb = runs.size();
    fb = '{8'h10, 8'h11, 8'h12, 8'h13};
    for (int i = 0; i < 4; i++) send_byte(fb[i], (i == 3));
    fb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    send_frame();
    wait_out(ob + 12, "t3");
    fb = '{8'h10, 8'h11, 8'h12, 8'h13};
    check_frame(ob, "t3a");
    fb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_frame(ob + 6, "t3b");
    check("t3_gap", ocyc[ob+6] - ocyc[ob+5], 2);
    check("t3_runs", runs.size() - rb, 2);

    // 4: DEPTH+1 bytes with no in_last -> a single ovf pulse and no output; then a good frame
    ob = oq.size(); ov0 = ovf_cnt;
    for (int i = 0; i < DEPTH + 1; i++) send_byte(8'(i), 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hEF, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (5) tick();
    check("t4_ovf_pulse", ovf_cnt - ov0, 1);
    check("t4_no_output", oq.size(), ob);
    fb = '{8'h55, 8'hAA, 8'h5A};
    send_frame();
    wait_out(ob + 5, "t4");
    check_frame(ob, "t4");

    // 5: one frame of exactly DEPTH bytes -> in_ready low while full, then high after the first pop
    ob = oq.size(); rb = runs.size(); ov0 = ovf_cnt;
    fb.delete();
    for (int i = 0; i < DEPTH; i++) fb.push_back(8'(i * 3 + 1));
    send_frame();
    @(negedge clk);
    check("t5_full_rdy", in_ready, 0);
    check("t5_idle_ov", out_valid, 0);
    @(negedge clk);
    check("t5_feed_ov", out_valid, 1);
    check("t5_feed_rdy", in_ready, 0);
    @(negedge clk);
    check("t5_pop_rdy", in_ready, 1);
    tick();
    wait_out(ob + DEPTH + 2, "t5");
    check_frame(ob, "t5");
    check("t5_run_len", runs[rb], DEPTH);
    check("t5_no_ovf", ovf_cnt - ov0, 0);

    // 6: reset during FEED -> outputs go to 0 at once; the next frame is still correct
    fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!eng_valid && k < 20);
    check("t6_feed_seen", eng_valid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    os = oq.size();
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_eng_valid", eng_valid, 0);
    check("t6_rst_eng_data", eng_data, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_in_ready", in_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("t6_no_partial", oq.size(), os);
    ob = oq.size();
    fb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame();
    wait_out(ob + 6, "t6");
    check_frame(ob, "t6");
    check("t6_eng_data_idle_zero", eng_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
